// File: rtl/ex_mem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : ex_mem_pkg                                               |
// | Description : Shared core constants used by the execute/memory         |
// |               pipeline register. Holds the stall-vector bit indices,   |
// |               the bubble constants and the registered payload record   |
// |               presented to the memory stage.                           |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
package ex_mem_pkg;

  // Stall vector bit positions, one per pipeline stage.
  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  // Bubble constants.
  localparam logic [31:0] ZERO_WORD    = 32'h0;
  localparam logic [4:0]  NOP_REG_ADDR = 5'h0;

  // Fixed datapath widths.
  localparam int DATA_W      = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int HILO_TEMP_W = 64;
  localparam int CNT_W       = 2;

  // Everything the memory stage receives from this register.
  typedef struct packed {
    logic                  valid;
    logic                  wreg;
    logic [REG_ADDR_W-1:0] waddr;
    logic [DATA_W-1:0]     wdata;
    logic                  we_hilo;
    logic [DATA_W-1:0]     wdata_hi;
    logic [DATA_W-1:0]     wdata_lo;
  } mem_payload_t;

  // A bubble writes nothing and carries all-zero data.
  localparam mem_payload_t PAYLOAD_BUBBLE = '{
    valid:    1'b0,
    wreg:     1'b0,
    waddr:    NOP_REG_ADDR,
    wdata:    ZERO_WORD,
    we_hilo:  1'b0,
    wdata_hi: ZERO_WORD,
    wdata_lo: ZERO_WORD
  };

endpackage : ex_mem_pkg
`default_nettype wire

// File: rtl/ex_mem.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : ex_mem                                                   |
// | Description : Execute -> memory pipeline register. Captures the GPR    |
// |               and HI/LO write results of execute, inserts bubbles,     |
// |               holds or flushes under control of the stall/flush unit,  |
// |               and returns the madd/msub accumulate temporaries to      |
// |               execute while execute is stalled on a multi-cycle op.    |
// | Ports       : clk, rst_ (async, active-low), stall[5:0], flush         |
// |               ex_o_*  : execute-stage results (inputs)                 |
// |               mem_i_* : registered payload to the memory stage         |
// |               ex_i_hilo_temp / ex_i_cnt : accumulate state to execute  |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module ex_mem
  import ex_mem_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_,
  input  logic [5:0]             stall,
  input  logic                   flush,
  input  logic                   ex_o_wreg,
  input  logic [REG_ADDR_W-1:0]  ex_o_waddr,
  input  logic [DATA_W-1:0]      ex_o_wdata,
  input  logic                   ex_o_we_hilo,
  input  logic [DATA_W-1:0]      ex_o_wdata_hi,
  input  logic [DATA_W-1:0]      ex_o_wdata_lo,
  input  logic [HILO_TEMP_W-1:0] ex_o_hilo_temp,
  input  logic [CNT_W-1:0]       ex_o_cnt,
  output logic                   mem_i_valid,
  output logic                   mem_i_wreg,
  output logic [REG_ADDR_W-1:0]  mem_i_waddr,
  output logic [DATA_W-1:0]      mem_i_wdata,
  output logic                   mem_i_we_hilo,
  output logic [DATA_W-1:0]      mem_i_wdata_hi,
  output logic [DATA_W-1:0]      mem_i_wdata_lo,
  output logic [HILO_TEMP_W-1:0] ex_i_hilo_temp,
  output logic [CNT_W-1:0]       ex_i_cnt
);

  mem_payload_t           r_payload;
  logic [HILO_TEMP_W-1:0] r_hilo_temp;
  logic [CNT_W-1:0]       r_cnt;
  mem_payload_t           w_capture;

  // Only the execute and memory stall bits matter to this register.
  logic w_unused_stall;
  assign w_unused_stall = ^{stall[STALL_PC], stall[STALL_IF],
                            stall[STALL_ID], stall[STALL_WB]};

  always_comb begin
    w_capture          = PAYLOAD_BUBBLE;
    w_capture.valid    = 1'b1;
    w_capture.wreg     = ex_o_wreg;
    w_capture.waddr    = ex_o_waddr;
    w_capture.wdata    = ex_o_wdata;
    w_capture.we_hilo  = ex_o_we_hilo;
    w_capture.wdata_hi = ex_o_wdata_hi;
    w_capture.wdata_lo = ex_o_wdata_lo;
  end

  // Priority: flush, execute-stalled/mem-free (bubble + keep accumulating),
  // both stalled (hold), otherwise normal capture. The illegal combination
  // of execute running with mem stalled falls through to normal capture.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_payload   <= PAYLOAD_BUBBLE;
      r_hilo_temp <= '0;
      r_cnt       <= '0;
    end else if (flush) begin
      r_payload   <= PAYLOAD_BUBBLE;
      r_hilo_temp <= '0;
      r_cnt       <= '0;
    end else if (stall[STALL_EX] && !stall[STALL_MEM]) begin
      r_payload   <= PAYLOAD_BUBBLE;
      r_hilo_temp <= ex_o_hilo_temp;
      r_cnt       <= ex_o_cnt;
    end else if (!stall[STALL_EX]) begin
      r_payload   <= w_capture;
      r_hilo_temp <= '0;
      r_cnt       <= '0;
    end
  end

  assign mem_i_valid    = r_payload.valid;
  assign mem_i_wreg     = r_payload.wreg;
  assign mem_i_waddr    = r_payload.waddr;
  assign mem_i_wdata    = r_payload.wdata;
  assign mem_i_we_hilo  = r_payload.we_hilo;
  assign mem_i_wdata_hi = r_payload.wdata_hi;
  assign mem_i_wdata_lo = r_payload.wdata_lo;
  assign ex_i_hilo_temp = r_hilo_temp;
  assign ex_i_cnt       = r_cnt;

endmodule : ex_mem
`default_nettype wire

// File: tb/tb_ex_mem.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_ex_mem                                                |
// | Description : Self-checking bench for ex_mem. A table of directed      |
// |               vectors with hand-computed expectations is applied one   |
// |               per clock, followed by hand-written reset sequences.     |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_ex_mem;

  logic        clk;
  logic        rst_;
  logic [5:0]  stall;
  logic        flush;
  logic        ex_o_wreg;
  logic [4:0]  ex_o_waddr;
  logic [31:0] ex_o_wdata;
  logic        ex_o_we_hilo;
  logic [31:0] ex_o_wdata_hi;
  logic [31:0] ex_o_wdata_lo;
  logic [63:0] ex_o_hilo_temp;
  logic [1:0]  ex_o_cnt;
  logic        mem_i_valid;
  logic        mem_i_wreg;
  logic [4:0]  mem_i_waddr;
  logic [31:0] mem_i_wdata;
  logic        mem_i_we_hilo;
  logic [31:0] mem_i_wdata_hi;
  logic [31:0] mem_i_wdata_lo;
  logic [63:0] ex_i_hilo_temp;
  logic [1:0]  ex_i_cnt;

  int checks = 0;
  int errors = 0;

  ex_mem dut (
    .clk            (clk),
    .rst_           (rst_),
    .stall          (stall),
    .flush          (flush),
    .ex_o_wreg      (ex_o_wreg),
    .ex_o_waddr     (ex_o_waddr),
    .ex_o_wdata     (ex_o_wdata),
    .ex_o_we_hilo   (ex_o_we_hilo),
    .ex_o_wdata_hi  (ex_o_wdata_hi),
    .ex_o_wdata_lo  (ex_o_wdata_lo),
    .ex_o_hilo_temp (ex_o_hilo_temp),
    .ex_o_cnt       (ex_o_cnt),
    .mem_i_valid    (mem_i_valid),
    .mem_i_wreg     (mem_i_wreg),
    .mem_i_waddr    (mem_i_waddr),
    .mem_i_wdata    (mem_i_wdata),
    .mem_i_we_hilo  (mem_i_we_hilo),
    .mem_i_wdata_hi (mem_i_wdata_hi),
    .mem_i_wdata_lo (mem_i_wdata_lo),
    .ex_i_hilo_temp (ex_i_hilo_temp),
    .ex_i_cnt       (ex_i_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The controller must never run execute while memory is stalled.
  always @(posedge clk) begin
    if (rst_ === 1'b1 && stall[3] === 1'b0 && stall[4] === 1'b1) begin
      errors++;
      $display("FAIL illegal_stall: got stall=%b required stall[3]=1 when stall[4]=1", stall);
    end
  end

  typedef struct {
    logic        flush;
    logic [5:0]  stall;
    logic        wreg;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        we_hilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] temp;
    logic [1:0]  cnt;
    logic        e_valid;
    logic        e_wreg;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_we_hilo;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    logic [63:0] e_temp;
    logic [1:0]  e_cnt;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, ".valid"},   {63'h0, mem_i_valid},    {63'h0, v.e_valid});
    chk({tag, ".wreg"},    {63'h0, mem_i_wreg},     {63'h0, v.e_wreg});
    chk({tag, ".waddr"},   {59'h0, mem_i_waddr},    {59'h0, v.e_waddr});
    chk({tag, ".wdata"},   {32'h0, mem_i_wdata},    {32'h0, v.e_wdata});
    chk({tag, ".we_hilo"}, {63'h0, mem_i_we_hilo},  {63'h0, v.e_we_hilo});
    chk({tag, ".hi"},      {32'h0, mem_i_wdata_hi}, {32'h0, v.e_hi});
    chk({tag, ".lo"},      {32'h0, mem_i_wdata_lo}, {32'h0, v.e_lo});
    chk({tag, ".temp"},    ex_i_hilo_temp,          v.e_temp);
    chk({tag, ".cnt"},     {62'h0, ex_i_cnt},       {62'h0, v.e_cnt});
  endtask

  task automatic drive(input vec_t v);
    flush          = v.flush;
    stall          = v.stall;
    ex_o_wreg      = v.wreg;
    ex_o_waddr     = v.waddr;
    ex_o_wdata     = v.wdata;
    ex_o_we_hilo   = v.we_hilo;
    ex_o_wdata_hi  = v.hi;
    ex_o_wdata_lo  = v.lo;
    ex_o_hilo_temp = v.temp;
    ex_o_cnt       = v.cnt;
  endtask

  vec_t zero_v;
  vec_t hv;

  initial begin
    // Columns: flush stall wreg waddr wdata we_hilo hi lo temp cnt |
    //          e_valid e_wreg e_waddr e_wdata e_we_hilo e_hi e_lo e_temp e_cnt
    // Normal capture after reset.
    vecs[0]  = '{1'b0, 6'b000000, 1'b1, 5'd1,  32'hDEADBEEF, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0,
                 1'b1, 1'b1, 5'd1,  32'hDEADBEEF, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0};
    // Back-to-back writes to 3, 4, 5.
    vecs[1]  = '{1'b0, 6'b000000, 1'b1, 5'd3,  32'h33, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0,
                 1'b1, 1'b1, 5'd3,  32'h33, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0};
    vecs[2]  = '{1'b0, 6'b000000, 1'b1, 5'd4,  32'h44, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0,
                 1'b1, 1'b1, 5'd4,  32'h44, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0};
    vecs[3]  = '{1'b0, 6'b000000, 1'b1, 5'd5,  32'h55, 1'b1, 32'hAAAA0000, 32'h5555FFFF, 64'h0, 2'd0,
                 1'b1, 1'b1, 5'd5,  32'h55, 1'b1, 32'hAAAA0000, 32'h5555FFFF, 64'h0, 2'd0};
    // Execute stalled, mem free: bubbles out, accumulate state follows ex (0 then 1).
    vecs[4]  = '{1'b0, 6'b001111, 1'b1, 5'd7,  32'h77, 1'b1, 32'h1, 32'h2, 64'h1234, 2'd0,
                 1'b0, 1'b0, 5'd0,  32'h0, 1'b0, 32'h0, 32'h0, 64'h1234, 2'd0};
    vecs[5]  = '{1'b0, 6'b001111, 1'b1, 5'd7,  32'h77, 1'b1, 32'h1, 32'h2, 64'h0000_0001_FFFF_FFFF, 2'd1,
                 1'b0, 1'b0, 5'd0,  32'h0, 1'b0, 32'h0, 32'h0, 64'h0000_0001_FFFF_FFFF, 2'd1};
    // Stall release: madd result registered, accumulate state cleared.
    vecs[6]  = '{1'b0, 6'b000000, 1'b0, 5'd0,  32'h0, 1'b1, 32'h2, 32'hFFFFFFFE, 64'h0000_0001_FFFF_FFFF, 2'd1,
                 1'b1, 1'b0, 5'd0,  32'h0, 1'b1, 32'h2, 32'hFFFFFFFE, 64'h0, 2'd0};
    // Execute stall, then both stalled: accumulate state held while ex changes.
    vecs[7]  = '{1'b0, 6'b001111, 1'b1, 5'd9,  32'h99, 1'b0, 32'h0, 32'h0, 64'hAB, 2'd1,
                 1'b0, 1'b0, 5'd0,  32'h0, 1'b0, 32'h0, 32'h0, 64'hAB, 2'd1};
    vecs[8]  = '{1'b0, 6'b011111, 1'b1, 5'd10, 32'h1010, 1'b1, 32'h5, 32'h6, 64'hCD, 2'd2,
                 1'b0, 1'b0, 5'd0,  32'h0, 1'b0, 32'h0, 32'h0, 64'hAB, 2'd1};
    // Flush beats the full stall and clears cnt=1.
    vecs[9]  = '{1'b1, 6'b011111, 1'b1, 5'd10, 32'h1010, 1'b1, 32'h5, 32'h6, 64'hCD, 2'd2,
                 1'b0, 1'b0, 5'd0,  32'h0, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0};
    // Real payload, then mem stall holds it while ex inputs change.
    vecs[10] = '{1'b0, 6'b000000, 1'b1, 5'd11, 32'hB1, 1'b1, 32'h11, 32'h22, 64'h0, 2'd0,
                 1'b1, 1'b1, 5'd11, 32'hB1, 1'b1, 32'h11, 32'h22, 64'h0, 2'd0};
    vecs[11] = '{1'b0, 6'b011111, 1'b0, 5'd12, 32'hC2, 1'b0, 32'h33, 32'h44, 64'hEE, 2'd3,
                 1'b1, 1'b1, 5'd11, 32'hB1, 1'b1, 32'h11, 32'h22, 64'h0, 2'd0};
    // Flush with no stall squashes the in-flight instruction.
    vecs[12] = '{1'b1, 6'b000000, 1'b1, 5'd12, 32'hC2, 1'b1, 32'h33, 32'h44, 64'hEE, 2'd3,
                 1'b0, 1'b0, 5'd0,  32'h0, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0};
    // All-ones boundary copy; accumulate inputs ignored when not stalled.
    vecs[13] = '{1'b0, 6'b000000, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3,
                 1'b1, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 2'd0};

    zero_v = '{1'b0, 6'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0,
               1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0};

    // Reset held with nonzero ex inputs: all outputs zero.
    rst_ = 1'b0;
    drive(vecs[13]);
    repeat (2) @(posedge clk);
    #1 chk_all("reset", zero_v);

    @(negedge clk);
    rst_ = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1 chk_all($sformatf("vec%0d", i), vecs[i]);
      @(negedge clk);
    end

    // Mid multi-cycle op: load cnt=1, then assert reset mid-cycle.
    drive(vecs[5]);
    @(posedge clk);
    #1 chk("pre_reset.cnt", {62'h0, ex_i_cnt}, 64'd1);
    #2 rst_ = 1'b0;
    #1 chk_all("async_reset", zero_v);

    // Release at a negedge; DEADBEEF appears after the next edge.
    @(negedge clk);
    rst_ = 1'b1;
    hv = vecs[0];
    drive(hv);
    #1 chk("post_release_pre_edge.valid", {63'h0, mem_i_valid}, 64'd0);
    @(posedge clk);
    #1 chk_all("post_release", hv);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: got no completion required completion before 100000");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule : tb_ex_mem
`default_nettype wire

// File: doc/ex_mem.md
# ex_mem

Pipeline register between the execute stage and the memory stage of the five-stage MIPS core. It captures the execute-stage result each cycle: GPR write control and data, HI/LO write, and the madd/msub accumulation temporaries. It presents that result to the memory stage one cycle later and inserts bubbles, holds or flushes according to the central stall/flush controller. It also feeds the two-cycle accumulate state (`hilo_temp`, `cnt`) back to execute while execute is stalled on a multi-cycle op.

## Interface
- Parameters: none. Widths are fixed: 32-bit data, 5-bit register address, 64-bit accumulate temp, 2-bit cycle count.
- clk  in  1  core clock; all state updates on the rising edge
- rst_  in  1  reset, asynchronous, active-low
- stall  in  6  stall vector: [0] pc, [1] if, [2] id, [3] ex, [4] mem, [5] wb
- flush  in  1  exception flush; squashes the in-flight instruction
- ex_o_wreg  in  1  GPR write enable from execute
- ex_o_waddr  in  5  GPR destination
- ex_o_wdata  in  32  GPR write data
- ex_o_we_hilo  in  1  HI/LO write enable
- ex_o_wdata_hi / ex_o_wdata_lo  in  32 each  HI/LO write data
- ex_o_hilo_temp  in  64  partial product from first madd/msub cycle
- ex_o_cnt  in  2  execute multi-cycle counter
- mem_i_valid  out  1  register holds a real instruction (not a bubble)
- mem_i_wreg, mem_i_waddr, mem_i_wdata  out  1/5/32  registered GPR write fields to mem
- mem_i_we_hilo, mem_i_wdata_hi, mem_i_wdata_lo  out  1/32/32  registered HI/LO fields to mem; also the mem-stage forwarding source for execute
- ex_i_hilo_temp  out  64  accumulate temp returned to execute
- ex_i_cnt  out  2  counter returned to execute

## Operation
- Two register groups:
  - payload: all `mem_i_*` outputs.
  - accumulate state: `ex_i_hilo_temp`, `ex_i_cnt`.
- Per-edge action, first match wins:
  1. flush=1: payload ← bubble; accumulate state ← 0.
  2. stall[3]=1 and stall[4]=0 (execute stalled, mem free): payload ← bubble; accumulate state ← `ex_o_hilo_temp`, `ex_o_cnt`.
  3. stall[3]=1 and stall[4]=1: payload and accumulate state hold.
  4. stall[3]=0: payload ← ex inputs, `mem_i_valid`←1; accumulate state ← 0.
- Bubble definition: `mem_i_valid`=0, `mem_i_wreg`=0, `mem_i_we_hilo`=0, `mem_i_waddr`=0, all data fields 0.
- stall[3]=0 with stall[4]=1 is illegal; the controller never produces it. The block takes action 4 anyway, and the bench asserts that this combination never occurs.
- No arithmetic is performed; fields are copied bit-exact.

## Timing
- Latency: ex inputs sampled at edge N appear on `mem_i_*` after edge N, stable for the whole of cycle N+1.
- Feedback latency: `ex_o_cnt`/`ex_o_hilo_temp` sampled at edge N appear on `ex_i_cnt`/`ex_i_hilo_temp` in cycle N+1. This closes the execute two-cycle madd/msub loop: cnt 0 → 1, then stall releases.
- Reset (rst_=0, asynchronous assert): every output is 0 immediately, including `mem_i_valid`=0. Deassertion takes effect at the next edge; the first capture follows the rules above.
- Reset mid-multi-cycle op clears `ex_i_cnt` to 0. Execute restarts the op from cycle 0.
- flush while stalled: flush wins, so payload and accumulate state are cleared even when stall[3] and stall[4] are both 1.
- All outputs come straight from flops, with no combinational path from inputs to outputs.

## Structure
- Stall bit indices belong in the shared defines file alongside the `EXE_OP_*`/`EXE_RES_*` constants: `STALL_PC`..`STALL_WB` (0..5).
- Bubble constants also go in that file: `ZERO_WORD` 32'h0, `NOP_REG_ADDR` 5'h0.
- Single flat module; no sub-module is needed.

## Test plan
- Reset: drive rst_=0 mid-cycle with nonzero ex inputs → all outputs 0 asynchronously; after release with stall=0, `ex_o_wdata`=32'hDEADBEEF appears on `mem_i_wdata` one edge later with `mem_i_valid`=1.
- Normal flow: back-to-back writes to waddr 3, 4, 5 → `mem_i_waddr` shows 3, 4, 5 on consecutive cycles, `mem_i_wreg`=1 throughout.
- Execute stall bubble: stall=6'b001111 for 2 cycles → `mem_i_valid`=0, `mem_i_wreg`=0, `mem_i_we_hilo`=0 both cycles; `ex_i_cnt` tracks `ex_o_cnt` (0→1).
- madd loop: `ex_o_hilo_temp`=64'h0000_0001_FFFF_FFFF with `ex_o_cnt`=1 under stall[3] → returned on `ex_i_hilo_temp`/`ex_i_cnt` next cycle; on stall release both return to 0 and the HI/LO result is registered.
- Mem stall hold: stall=6'b011111 with ex inputs changing → all outputs frozen at their previous values.
- Flush priority: flush=1 together with stall=6'b011111 and `ex_i_cnt`=1 → next cycle all payload outputs are 0 and `ex_i_cnt`=0.
